vin_quadencoder_ctrl: RTL and testbench



---
 rtl/vin_quadencoder_ctrl.sv | 175 +++++++++++++++++
 tb/tb_vin_quadencoder_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vin_quadencoder_ctrl.sv
// Single-channel x4 quadrature controller: synchronized/filtered A/B/Z, position
// counter with illegal-transition count, index homing handshake and velocity sampling.
module vin_quadencoder_ctrl #(
    parameter int BITS       = 32,
    parameter int FILTER     = 3,
    parameter int VEL_PERIOD = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            quadA,
    input  logic            quadB,
    input  logic            quadZ,
    input  logic            index_enable,
    input  logic            err_clear,
    output logic [BITS-1:0] pos,
    output logic [BITS-1:0] index_pos,
    output logic            index_done,
    output logic [BITS-1:0] velocity,
    output logic            vel_valid,
    output logic [7:0]      err_count
);

    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(VEL_PERIOD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Bit order through the input path: [2]=A, [1]=B, [0]=Z
    logic [2:0]      sync1_q, sync2_q, filt_q;
    logic [FW-1:0]   fcnt_q [3];
    logic [1:0]      prev_ab_q;
    logic            z_prev_q;

    logic [BITS-1:0] pos_q, pos_d;
    logic [BITS-1:0] snap_q, snap_adj;
    logic [BITS-1:0] vel_q;
    logic            vel_valid_q;
    logic [TW-1:0]   tmr_q;
    logic [7:0]      err_q;

    state_t          state_q;
    logic            index_done_q;
    logic [BITS-1:0] index_pos_q;

    logic            step_up, step_dn, illegal;
    logic            z_rise, capture, vel_tc;

    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        illegal = 1'b0;
        case ({prev_ab_q, filt_q[2:1]})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_up = 1'b1;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: step_dn = 1'b1;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: illegal = 1'b1;
            default: ;
        endcase
    end

    assign z_rise  = filt_q[0] & ~z_prev_q;
    assign capture = (state_q == S_ARMED) && index_enable && z_rise;
    assign vel_tc  = (tmr_q == TW'(VEL_PERIOD - 1));

    // A capture zeroes pos and drops any step decoded on the same edge
    always_comb begin
        if (capture)
            pos_d = '0;
        else if (step_up)
            pos_d = pos_q + BITS'(1);
        else if (step_dn)
            pos_d = pos_q - BITS'(1);
        else
            pos_d = pos_q;
        snap_adj = capture ? (snap_q - pos_q) : snap_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            filt_q    <= '0;
            for (int i = 0; i < 3; i++) fcnt_q[i] <= '0;
            prev_ab_q <= '0;
            z_prev_q  <= 1'b0;
        end else begin
            sync1_q   <= {quadA, quadB, quadZ};
            sync2_q   <= sync1_q;
            prev_ab_q <= filt_q[2:1];
            z_prev_q  <= filt_q[0];
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] != filt_q[i]) begin
                    if (fcnt_q[i] == FW'(FILTER - 1)) begin
                        filt_q[i] <= sync2_q[i];
                        fcnt_q[i] <= '0;
                    end else begin
                        fcnt_q[i] <= fcnt_q[i] + FW'(1);
                    end
                end else begin
                    fcnt_q[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q       <= '0;
            snap_q      <= '0;
            vel_q       <= '0;
            vel_valid_q <= 1'b0;
            tmr_q       <= '0;
            err_q       <= '0;
        end else begin
            pos_q <= pos_d;
            if (err_clear)
                err_q <= '0;
            else if (illegal && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
            vel_valid_q <= vel_tc;
            if (vel_tc) begin
                tmr_q  <= '0;
                vel_q  <= pos_d - snap_adj;
                snap_q <= pos_d;
            end else begin
                tmr_q  <= tmr_q + TW'(1);
                snap_q <= snap_adj;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            index_done_q <= 1'b0;
            index_pos_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (index_enable) state_q <= S_ARMED;
                end
                S_ARMED: begin
                    if (!index_enable) begin
                        state_q <= S_IDLE;
                    end else if (capture) begin
                        state_q      <= S_DONE;
                        index_done_q <= 1'b1;
                        index_pos_q  <= pos_q;
                    end
                end
                S_DONE: begin
                    if (!index_enable) begin
                        state_q      <= S_IDLE;
                        index_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    index_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign pos        = pos_q;
    assign index_pos  = index_pos_q;
    assign index_done = index_done_q;
    assign velocity   = vel_q;
    assign vel_valid  = vel_valid_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_vin_quadencoder_ctrl.sv
// Bench for vin_quadencoder_ctrl: directed scenarios plus random stimulus, all
// outputs compared every cycle against a behavioural model of the encoder channel.
module tb_vin_quadencoder_ctrl;

    localparam int BITS   = 32;
    localparam int FILTER = 3;
    localparam int VP     = 16;

    logic            clk, rst;
    logic            quadA, quadB, quadZ, index_enable, err_clear;
    logic [BITS-1:0] pos, index_pos, velocity;
    logic            index_done, vel_valid;
    logic [7:0]      err_count;

    int nvec = 0;
    int nmis = 0;
    bit checking = 0;
    int ph = 0;

    vin_quadencoder_ctrl #(.BITS(BITS), .FILTER(FILTER), .VEL_PERIOD(VP)) dut (
        .clk(clk), .rst(rst), .quadA(quadA), .quadB(quadB), .quadZ(quadZ),
        .index_enable(index_enable), .err_clear(err_clear),
        .pos(pos), .index_pos(index_pos), .index_done(index_done),
        .velocity(velocity), .vel_valid(vel_valid), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Position of an {A,B} level within the Gray cycle 00,10,11,01
    function automatic int phase_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ab_of(input int p);
        case (p % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_ARMED = 1, M_DONE = 2;
    logic [2:0]      m_s1, m_s2, m_f;
    int              m_run [3];
    logic [1:0]      m_prevab;
    logic            m_zprev;
    logic [BITS-1:0] m_pos, m_idx, m_snap, m_vel, m_nxt, m_base;
    int              m_mode, m_err, m_tmr, m_d;
    logic            m_done, m_vv, m_zr, m_cap;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_f = '0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            m_prevab = '0; m_zprev = 0;
            m_pos = '0; m_idx = '0; m_snap = '0; m_vel = '0;
            m_mode = M_IDLE; m_err = 0; m_tmr = 0; m_done = 0; m_vv = 0;
        end else begin
            m_d   = (phase_of(m_f[2:1]) - phase_of(m_prevab) + 4) % 4;
            m_zr  = m_f[0] && !m_zprev;
            m_cap = (m_mode == M_ARMED) && index_enable && m_zr;
            if (m_cap)          m_nxt = '0;
            else if (m_d == 1)  m_nxt = m_pos + 1;
            else if (m_d == 3)  m_nxt = m_pos - 1;
            else                m_nxt = m_pos;
            if (err_clear)                   m_err = 0;
            else if (m_d == 2 && m_err < 255) m_err = m_err + 1;
            m_base = m_cap ? m_snap - m_pos : m_snap;
            if (m_tmr == VP - 1) begin
                m_vel = m_nxt - m_base; m_snap = m_nxt; m_vv = 1; m_tmr = 0;
            end else begin
                m_snap = m_base; m_vv = 0; m_tmr = m_tmr + 1;
            end
            if (m_cap) m_idx = m_pos;
            case (m_mode)
                M_IDLE:  if (index_enable) m_mode = M_ARMED;
                M_ARMED: if (!index_enable) m_mode = M_IDLE; else if (m_zr) m_mode = M_DONE;
                default: if (!index_enable) m_mode = M_IDLE;
            endcase
            m_done   = (m_mode == M_DONE);
            m_pos    = m_nxt;
            m_prevab = m_f[2:1];
            m_zprev  = m_f[0];
            for (int i = 0; i < 3; i++) begin
                if (m_s2[i] != m_f[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= FILTER) begin
                        m_f[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {quadA, quadB, quadZ};
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            nvec++;
            if (pos !== m_pos || index_pos !== m_idx || index_done !== m_done ||
                velocity !== m_vel || vel_valid !== m_vv || err_count !== 8'(m_err)) begin
                nmis++;
                $display("FAIL model t=%0t: pos=%0h/%0h idx=%0h/%0h done=%0b/%0b vel=%0h/%0h vv=%0b/%0b err=%0d/%0d (dut/model)",
                         $time, pos, m_pos, index_pos, m_idx, index_done, m_done,
                         velocity, m_vel, vel_valid, m_vv, err_count, m_err);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ph(input int p);
        logic [1:0] ab;
        ph = p;
        ab = ab_of(p);
        quadA = ab[1];
        quadB = ab[0];
    endtask

    task automatic step(input int dir, input int hold);
        set_ph((ph + dir + 4) % 4);
        tick(hold);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic z_pulse();
        quadZ = 1'b1;
        tick(8);
        quadZ = 1'b0;
        tick(8);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int first, vchk, hold;
        logic [BITS-1:0] p0;
        rst = 1'b0; quadA = 0; quadB = 0; quadZ = 0; index_enable = 0; err_clear = 0;
        #2 rst = 1'b1;
        #1 checking = 1;
        check("reset_pos", pos, 0);
        check("reset_err", err_count, 0);
        check("reset_done", index_done, 0);
        tick(3);
        rst = 1'b0;
        tick(3);

        // Latency and forward counting
        set_ph(1);
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            if (pos != 0 && first == 0) first = i;
        end
        check("latency_edges", first, 6);
        tick(2);
        for (int s = 0; s < 7; s++) step(1, 10);
        check("fwd8_pos", pos, 8);
        check("fwd8_err", err_count, 0);

        // Reverse from zero wraps; short glitch is rejected
        do_reset(2);
        for (int s = 0; s < 3; s++) step(-1, 10);
        check("rev3_pos", pos, 32'hFFFF_FFFD);
        quadA = ~quadA;
        tick(2);
        quadA = ~quadA;
        tick(10);
        check("glitch_pos", pos, 32'hFFFF_FFFD);

        // Illegal transitions saturate err_count; err_clear wins
        for (int s = 0; s < 300; s++) step(2, 4);
        tick(6);
        check("illegal_pos", pos, 32'hFFFF_FFFD);
        check("err_sat", err_count, 255);
        set_ph((ph + 2) % 4);
        tick(5);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        check("err_clear_wins", err_count, 0);
        tick(8);
        check("err_stays_clear", err_count, 0);

        // Index homing at pos=100
        step(1, 10);
        do_reset(2);
        for (int s = 0; s < 100; s++) step(1, 4);
        tick(6);
        check("pre_index_pos", pos, 100);
        index_enable = 1'b1;
        tick(2);
        z_pulse();
        check("index_pos", index_pos, 100);
        check("index_zeroed", pos, 0);
        check("index_done_hi", index_done, 1);
        index_enable = 1'b0;
        tick(1);
        check("index_done_lo", index_done, 0);
        z_pulse();
        check("z_ignored_pos", pos, 0);
        check("z_ignored_idx", index_pos, 100);

        // Steady velocity across a mid-period zeroing
        index_enable = 1'b1;
        tick(1);
        vchk = 0;
        for (int s = 0; s < 24; s++) begin
            set_ph((ph + 1) % 4);
            for (int t = 0; t < 4; t++) begin
                if (s == 10 && t == 2) quadZ = 1'b1;
                if (s == 12 && t == 2) quadZ = 1'b0;
                tick(1);
                if (s >= 6 && vel_valid) begin
                    check("vel_steady", velocity, 4);
                    vchk++;
                end
            end
        end
        check("vel_samples_seen", (vchk >= 4), 1);
        check("vel_index_pos", index_pos, 11);
        check("vel_index_done", index_done, 1);

        // Reset while ARMED, then re-arm with index_enable held
        index_enable = 1'b0;
        do_reset(2);
        for (int s = 0; s < 50; s++) step(1, 4);
        tick(6);
        check("pre_rst_pos", pos, 50);
        index_enable = 1'b1;
        tick(2);
        rst = 1'b1;
        #1;
        check("rst_pos", pos, 0);
        check("rst_idx", index_pos, 0);
        check("rst_vel", velocity, 0);
        check("rst_vv", vel_valid, 0);
        check("rst_err", err_count, 0);
        check("rst_done", index_done, 0);
        tick(3);
        rst = 1'b0;
        tick(8);
        p0 = pos;
        for (int s = 0; s < 5; s++) step(1, 4);
        tick(6);
        check("rearm_pos", pos, p0 + 5);
        z_pulse();
        check("rearm_idx", index_pos, p0 + 5);
        check("rearm_done", index_done, 1);
        check("rearm_zeroed", pos, 0);

        // Random traffic against the model
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                case ($urandom_range(0, 9))
                    0:             set_ph((ph + 2) % 4);
                    1, 2, 3, 4:    set_ph((ph + 1) % 4);
                    5, 6, 7, 8:    set_ph((ph + 3) % 4);
                    default:       ;
                endcase
                hold = $urandom_range(1, 6);
            end
            hold--;
            if ($urandom_range(0, 7) == 0)  quadZ = ~quadZ;
            if ($urandom_range(0, 24) == 0) index_enable = ~index_enable;
            err_clear = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        rst = 1'b0;
        err_clear = 1'b0;
        tick(4);

        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
